clk_divide_prog: RTL and testbench

- Runtime-programmable integer clock divider. Generates a registered divided clock enable/strobe `o_clk` with programmable period and high time, plus a one-cycle `o_sync` pulse at each period start.
- Generalises the fixed divide-by-50 block with run-time divisor and duty programming, a valid/ready configuration handshake, enable and resync.
- New settings apply glitch-free, only at period boundaries.
- Sits beside the excitation/ADC timing logic; downstream blocks sample `o_sync` to frame acquisitions.

---
 rtl/clk_divide_prog.sv | 171 +++++++++++++++++
 tb/tb_clk_divide_prog.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divide_prog.sv
// -----------------------------------------------------------------------------
// clk_divide_prog
//
// Runtime-programmable integer clock divider. Produces a registered divided
// clock o_clk with a programmable period N and high time H, and a one-cycle
// o_sync strobe at each period start. New {N, H} settings are accepted through
// a valid/ready handshake, parked in a pending register and applied only at a
// period boundary (terminal count or resync), or immediately while counting is
// disabled. This means a running period always completes with its old values.
//
// Ports
//   i_clk        : single clock
//   i_rst        : synchronous, active-high reset (highest priority)
//   i_en         : count enable; 0 freezes counter and o_clk
//   i_resync     : force an immediate period restart
//   i_cfg_valid  : configuration request
//   o_cfg_ready  : configuration can be accepted (pending register empty)
//   i_cfg_div    : requested period N
//   i_cfg_high   : requested high time H
//   o_cfg_err    : one-cycle pulse after an invalid configuration transfer
//   o_clk        : divided clock, registered
//   o_sync       : one-cycle period-start pulse, registered
//   o_cnt        : current phase counter
// -----------------------------------------------------------------------------
module clk_divide_prog #(
    parameter int CNT_W        = 16,
    parameter int DIV_DEFAULT  = 50,
    parameter int HIGH_DEFAULT = 25
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_resync,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [CNT_W-1:0] i_cfg_div,
    input  logic [CNT_W-1:0] i_cfg_high,
    output logic             o_cfg_err,
    output logic             o_clk,
    output logic             o_sync,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(HIGH_DEFAULT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);

    // A configuration is usable only if 2 <= div and 1 <= high < div.
    function automatic logic cfg_is_valid(input logic [CNT_W-1:0] div,
                                          input logic [CNT_W-1:0] high);
        return (div >= TWO) && (high >= ONE) && (high < div);
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             sync_q, sync_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pend_vld_q, pend_vld_d;

    logic [CNT_W-1:0] div_m1_s;
    logic [CNT_W-1:0] high_m1_s;
    logic             term_s;
    logic             boundary_s;
    logic             xfer_s;
    logic             apply_s;

    // Next-state logic for counter, waveform, handshake and config registers.
    always_comb begin
        cnt_d       = cnt_q;
        clk_d       = clk_q;
        sync_d      = 1'b0;
        err_d       = 1'b0;
        div_d       = div_q;
        high_d      = high_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pend_vld_d  = pend_vld_q;

        // Validation keeps div >= 2 and high >= 1, so these never wrap.
        div_m1_s  = div_q - ONE;
        high_m1_s = high_q - ONE;

        // ">=" rather than "==": a config applied while disabled may leave
        // cnt beyond the new N-1; the next counting edge then ends the period.
        term_s     = i_en && (cnt_q >= div_m1_s);
        boundary_s = i_resync || term_s;
        xfer_s     = i_cfg_valid && ready_q;
        apply_s    = pend_vld_q && (boundary_s || !i_en);

        if (boundary_s) begin
            cnt_d  = ZERO;
            clk_d  = 1'b1;
            sync_d = 1'b1;
        end else if (i_en) begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == high_m1_s) begin
                clk_d = 1'b0;
            end else begin
                clk_d = clk_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        // Apply and transfer are mutually exclusive: transfer needs ready,
        // which is low whenever something is pending.
        if (apply_s) begin
            div_d      = pend_div_q;
            high_d     = pend_high_q;
            pend_vld_d = 1'b0;
        end else begin
            div_d  = div_q;
            high_d = high_q;
        end

        if (xfer_s) begin
            if (cfg_is_valid(i_cfg_div, i_cfg_high)) begin
                pend_div_d  = i_cfg_div;
                pend_high_d = i_cfg_high;
                pend_vld_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end

        ready_d = !pend_vld_d;
    end

    // State registers with synchronous reset restoring the default config.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q       <= ZERO;
            clk_q       <= 1'b0;
            sync_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            div_q       <= DIV_RST;
            high_q      <= HIGH_RST;
            pend_div_q  <= ZERO;
            pend_high_q <= ZERO;
            pend_vld_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            clk_q       <= clk_d;
            sync_q      <= sync_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

    assign o_cnt       = cnt_q;
    assign o_clk       = clk_q;
    assign o_sync      = sync_q;
    assign o_cfg_err   = err_q;
    assign o_cfg_ready = ready_q;

endmodule

// File: tb/tb_clk_divide_prog.sv
// -----------------------------------------------------------------------------
// Testbench for clk_divide_prog: directed scenarios followed by random traffic.
// Each cycle the driver steps a behavioural model and pushes the expected
// outputs; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_clk_divide_prog;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic             clk;
        logic             sync;
        logic [CNT_W-1:0] cnt;
        logic             ready;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_en = 1'b0;
    logic             i_resync = 1'b0;
    logic             i_cfg_valid = 1'b0;
    logic             o_cfg_ready;
    logic [CNT_W-1:0] i_cfg_div = '0;
    logic [CNT_W-1:0] i_cfg_high = '0;
    logic             o_cfg_err;
    logic             o_clk;
    logic             o_sync;
    logic [CNT_W-1:0] o_cnt;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    // Reference model state: phase, waveform level, active and pending config.
    int m_phase = 0;
    bit m_clk = 0;
    int m_n = 50;
    int m_h = 25;
    bit m_pend = 0;
    int m_pn = 0;
    int m_ph = 0;
    bit m_ready = 1;

    clk_divide_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(50), .HIGH_DEFAULT(25)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_resync    (i_resync),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_div   (i_cfg_div),
        .i_cfg_high  (i_cfg_high),
        .o_cfg_err   (o_cfg_err),
        .o_clk       (o_clk),
        .o_sync      (o_sync),
        .o_cnt       (o_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, predict the outputs after the next rising
    // edge, queue the prediction, then advance past that edge.
    task automatic cyc(input bit rst, input bit en, input bit rs,
                       input bit v, input int dv, input int hi);
        exp_t e;
        bit   period_start;
        bit   take;
        bit   ok;
        i_rst       = rst;
        i_en        = en;
        i_resync    = rs;
        i_cfg_valid = v;
        i_cfg_div   = CNT_W'(dv);
        i_cfg_high  = CNT_W'(hi);
        if (rst) begin
            m_phase = 0; m_clk = 0; m_n = 50; m_h = 25;
            m_pend = 0; m_ready = 1;
            e = '{clk: 1'b0, sync: 1'b0, cnt: '0, ready: 1'b1, err: 1'b0};
        end else begin
            ok   = (dv >= 2) && (hi >= 1) && (hi < dv);
            take = v && m_ready;
            period_start = rs || (en && (m_phase >= m_n - 1));
            // Waveform: high from each period start until phase H-1 is counted.
            if (period_start) begin
                m_clk = 1;
                m_phase = 0;
            end else if (en) begin
                if (m_phase == m_h - 1) m_clk = 0;
                m_phase = m_phase + 1;
            end
            if (m_pend && (period_start || !en)) begin
                m_n = m_pn; m_h = m_ph; m_pend = 0;
            end
            if (take && ok) begin
                m_pn = dv; m_ph = hi; m_pend = 1;
            end
            m_ready = !m_pend;
            e.clk   = m_clk;
            e.sync  = period_start;
            e.cnt   = CNT_W'(m_phase);
            e.ready = m_ready;
            e.err   = take && !ok;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{clk: o_clk, sync: o_sync, cnt: o_cnt, ready: o_cfg_ready, err: o_cfg_err};
            tests = tests + 1;
            if (got !== e) begin
                fails = fails + 1;
                $display("FAIL scoreboard t=%0t: got clk=%b sync=%b cnt=%0d rdy=%b err=%b, expected clk=%b sync=%b cnt=%0d rdy=%b err=%b",
                         $time, got.clk, got.sync, got.cnt, got.ready, got.err,
                         e.clk, e.sync, e.cnt, e.ready, e.err);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        tests = tests + 1;
        if (act != req) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        int highs;
        int r;
        bit rst_r, en_r, rs_r, v_r;
        int dv, hi;

        // Reset state.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        chk("reset_cnt", int'(o_cnt), 0);
        chk("reset_ready", int'(o_cfg_ready), 1);

        // Defaults 50/25: first sync 50 cycles after reset release.
        run(49, 1);
        chk("pre_sync_cnt", int'(o_cnt), 49);
        chk("pre_sync_sync", int'(o_sync), 0);
        chk("pre_sync_clk", int'(o_clk), 0);
        run(1, 1);
        chk("first_sync", int'(o_sync), 1);
        chk("first_rise", int'(o_clk), 1);
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            run(1, 1);
            if (o_clk) highs++;
        end
        chk("high_count_50_25", highs, 25);
        chk("second_sync", int'(o_sync), 1);

        // Mid-period reconfiguration to 4/1.
        run(10, 1);
        chk("cnt_at_10", int'(o_cnt), 10);
        cyc(0, 1, 0, 1, 4, 1);
        chk("ready_low_after_cfg", int'(o_cfg_ready), 0);
        run(38, 1);
        chk("old_period_last", int'(o_cnt), 49);
        chk("still_pending", int'(o_cfg_ready), 0);
        run(1, 1);
        chk("boundary_sync", int'(o_sync), 1);
        run(1, 1);
        chk("ready_back", int'(o_cfg_ready), 1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            run(1, 1);
            if (o_clk) highs++;
        end
        chk("high_count_4_1", highs, 3);

        // Invalid configurations.
        cyc(0, 1, 0, 1, 1, 1);
        chk("err_div1", int'(o_cfg_err), 1);
        chk("err_div1_ready", int'(o_cfg_ready), 1);
        cyc(0, 1, 0, 1, 8, 0);
        chk("err_high0", int'(o_cfg_err), 1);
        cyc(0, 1, 0, 1, 8, 8);
        chk("err_high_eq_div", int'(o_cfg_err), 1);
        run(1, 1);
        chk("err_pulse_ends", int'(o_cfg_err), 0);
        run(12, 1);

        // Enable low for 7 cycles at cnt=30.
        cyc(1, 0, 0, 0, 0, 0);
        run(30, 1);
        run(7, 0);
        chk("frozen_cnt", int'(o_cnt), 30);
        chk("frozen_clk", int'(o_clk), 0);
        run(19, 1);
        chk("stretched_sync", int'(o_sync), 0);
        run(1, 1);
        chk("stretched_sync_57", int'(o_sync), 1);

        // Resync with pending 10/5.
        cyc(1, 0, 0, 0, 0, 0);
        run(39, 1);
        cyc(0, 1, 0, 1, 10, 5);
        cyc(0, 1, 1, 0, 0, 0);
        chk("resync_cnt", int'(o_cnt), 0);
        chk("resync_sync", int'(o_sync), 1);
        chk("resync_clk", int'(o_clk), 1);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            run(1, 1);
            if (o_clk) highs++;
        end
        chk("high_count_10_5", highs, 10);

        // Reset with pending config and simultaneous resync.
        cyc(1, 0, 0, 0, 0, 0);
        run(19, 1);
        cyc(0, 1, 0, 1, 6, 2);
        cyc(1, 1, 1, 0, 0, 0);
        chk("rst_cnt", int'(o_cnt), 0);
        chk("rst_sync", int'(o_sync), 0);
        chk("rst_clk", int'(o_clk), 0);
        chk("rst_ready", int'(o_cfg_ready), 1);
        run(50, 1);
        chk("defaults_restored", int'(o_sync), 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r     = int'($urandom_range(999));
            rst_r = (r < 5);
            en_r  = ($urandom_range(99) < 88);
            rs_r  = ($urandom_range(99) < 2);
            v_r   = ($urandom_range(99) < 10);
            dv    = int'($urandom_range(20));
            hi    = int'($urandom_range(dv + 1));
            cyc(rst_r, en_r, rs_r, v_r, dv, hi);
        end

        run(2, 1);
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
